// File: rtl/shift_reg_siso.sv
// ============================================================================
// shift_reg_siso : serial-in serial-out shift register, DEPTH single-bit stages
// Revision: 1.0
// ============================================================================
`default_nettype none

module shift_reg_siso #(
   parameter int   DEPTH       = 4,
   parameter logic RESET_VALUE = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [DEPTH-1:0] stage_q;
   logic [DEPTH-1:0] stage_d;

   // stage[0] takes the serial input; every later stage takes its predecessor
   always_comb begin
      stage_d    = stage_q;
      stage_d[0] = d;
      for (int i = 1; i < DEPTH; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stage_q <= {DEPTH{RESET_VALUE}};
      end else begin
         stage_q <= stage_d;
      end
   end

   assign q = stage_q[DEPTH-1];

endmodule

`default_nettype wire

// File: tb/tb_shift_reg_siso.sv
// Bench for shift_reg_siso: DEPTH 1, 2, 4 and 8 instances share one serial input
// and are checked against a history-queue reference after every rising edge.
`timescale 1ns/1ps
`default_nettype none

module tb_shift_reg_siso;

   logic clk;
   logic reset;
   logic d;
   logic q1, q2, q4, q8;

   int passed = 0;
   int total  = 0;

   // Every bit sampled since the last reset, oldest first
   logic hist[$];

   shift_reg_siso #(.DEPTH(1)) dut1 (.clk(clk), .reset(reset), .d(d), .q(q1));
   shift_reg_siso #(.DEPTH(2)) dut2 (.clk(clk), .reset(reset), .d(d), .q(q2));
   shift_reg_siso #(.DEPTH(4)) dut4 (.clk(clk), .reset(reset), .d(d), .q(q4));
   shift_reg_siso #(.DEPTH(8)) dut8 (.clk(clk), .reset(reset), .d(d), .q(q8));

   initial begin
      clk = 1'b0;
      forever #0.5 clk = ~clk;
   end

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         hist.delete();
      end else begin
         hist.push_back(d);
         if (hist.size() > 80) void'(hist.pop_front());
      end
   end

   // A DEPTH-stage register shows the bit sampled DEPTH edges ago, or the
   // reset value until that many bits have been sampled since reset.
   function automatic logic model_q(input int depth);
      int n;
      n = hist.size();
      if (n >= depth) return hist[n-depth];
      return 1'b0;
   endfunction

   task automatic chk(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp);
   endtask

   task automatic chk_model();
      chk("model_d1", q1, model_q(1));
      chk("model_d2", q2, model_q(2));
      chk("model_d4", q4, model_q(4));
      chk("model_d8", q8, model_q(8));
   endtask

   // Drive d between edges, then check 0.1 ns after the next rising edge
   task automatic step(input logic nd);
      d = nd;
      @(posedge clk);
      #0.1;
      chk_model();
      #0.1;
   endtask

   initial begin
      logic [7:0] basic_d;
      logic [7:0] basic_q4;
      logic [7:0] const_q4;

      // index 0 is applied first
      basic_d  = 8'b1111_0101;
      basic_q4 = 8'b1010_1000;
      const_q4 = 8'b1111_1000;

      reset = 1'b0;
      d     = 1'b1;
      #0.7;

      // Reset held with d=1 across several edges
      for (int i = 0; i < 3; i++) begin
         step(1'b1);
         chk("reset_hold_q4", q4, 1'b0);
         chk("reset_hold_q1", q1, 1'b0);
      end

      // Release reset and stream 1,0,1,0,1 then hold d at 1
      reset = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step(basic_d[i]);
         chk("basic_q4", q4, basic_q4[i]);
      end

      // Stages are full of ones; reset pulse between edges clears at once
      chk("prefill_q1", q1, 1'b1);
      reset = 1'b0;
      #0.1;
      chk("async_q1", q1, 1'b0);
      chk("async_q2", q2, 1'b0);
      chk("async_q4", q4, 1'b0);
      chk("async_q8", q8, 1'b0);
      chk("async_stage4", (dut4.stage_q === 4'b0000), 1'b1);
      reset = 1'b1;
      #0.1;

      // Constant ones after the pulse: q4 is 1 from the 4th edge onward
      for (int i = 0; i < 8; i++) begin
         step(1'b1);
         chk("const_q4", q4, const_q4[i]);
      end

      // Alternating 1,0: once filled, q4 alternates 1,0 on every edge
      for (int j = 0; j < 8; j++) begin
         step((j % 2) == 0);
         if (j >= 3) chk("alt_q4", q4, (j % 2) == 1);
      end

      // d toggling between edges has no effect until the next edge
      d = 1'b0;
      @(posedge clk);
      #0.1;
      d = 1'b1;
      #0.1;
      chk("glitch_q1", q1, 1'b0);
      d = 1'b0;
      #0.5;
      chk_model();

      // Random stream across all depths
      for (int k = 0; k < 200; k++) begin
         step(1'($urandom_range(0, 1)));
      end

      // Reset once more mid random stream, then refill
      reset = 1'b0;
      #0.1;
      chk("late_reset_q8", q8, 1'b0);
      reset = 1'b1;
      #0.1;
      for (int k = 0; k < 20; k++) begin
         step(1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire
